rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and controller for a shared N-to-1 mux datapath.
- N requesters with valid/ready handshakes share one registered output channel.
- The block decides who drives the mux select each cycle, issues per-requester ready, and registers the selected beat.
- It sits between multiple producer blocks and a single downstream consumer.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 8, width of one data beat.
- IDX_W, $clog2(N_REQ), width of the grant index (localparam, not overridable).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N_REQ  per-requester beat valid.
- in_data  input  N_REQ*DATA_W  packed beats; requester i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N_REQ  per-requester accept; one-hot or zero.
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_W  registered output beat.
- out_ready  input  1  downstream accept.
- grant_idx  output  IDX_W  index of the requester whose beat is currently in the output register.

Behaviour:
- Reset (async, while rst_n=0):
  - out_valid=0, out_data=0, grant_idx=0, round-robin pointer ptr=0.
  - in_ready is all-zero because no requester wins during reset.
- Load condition: load = !out_valid || out_ready. The single output register accepts a new beat when it is empty or drains in the same cycle.
- Arbitration (combinational, every cycle):
  - Search in_valid starting at index ptr, ascending, wrapping N_REQ-1 -> 0.
  - The first set bit is the winner.
  - in_ready[winner] = load. All other in_ready bits are 0.
  - If no in_valid bit is set, in_ready = 0.
- On a clock edge with load=1 and a winner:
  - out_data <= in_data[winner]; out_valid <= 1; grant_idx <= winner.
  - ptr <= winner+1, wrapping to 0 when winner = N_REQ-1.
- On a clock edge with load=1 and no winner: out_valid <= 0. out_data, grant_idx and ptr hold.
- With load=0 (out_valid=1, out_ready=0): all state holds and out_data stays stable (backpressure).
- Latency: an accepted beat appears on out_data the next cycle. Full throughput is one beat per cycle when out_ready=1.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,...,N_REQ-1,0,... A requester waits at most N_REQ-1 grants.
- Handshake rules:
  - Requesters must hold in_valid/in_data until in_ready.
  - The arbiter never asserts in_ready for a requester whose in_valid is 0.
- A lone requester wins every cycle, regardless of ptr.
- Reset mid-transfer discards any held beat. No in_ready pulse is produced during reset.

Optional Feature:
- Macro: RR_MUX_ARBITER_LOCK_EN.
- When defined:
  - Adds input in_last [N_REQ] (packet end marker per requester) and output out_last [1], which is registered alongside out_data.
  - A lock flag is set when a beat with in_last=0 is accepted.
  - While locked, only the locked requester (grant_idx) may win, even if others are valid.
  - Lock clears when that requester's beat with in_last=1 is accepted. ptr then advances past it.
  - Reset clears the lock and out_last.
- When undefined: no in_last/out_last ports and no lock state. Every beat is arbitrated independently.

Decomposition:
- Package rr_mux_arbiter_pkg:
  - function rr_pick(valid, ptr) returning {found, idx}.
  - Default parameter constants.
- Sub-module rr_mux_arbiter_pick: purely combinational round-robin priority search with masked/unmasked double scan. It is instantiated once.
- The top holds the registers, load logic, lock logic and the data mux.

Test Plan:
- Reset, then in_valid=4'b0000 -> out_valid=0, in_ready=0, grant_idx=0 for 10 cycles. Mid-stream rst_n=0 -> out_valid drops immediately.
- All 4 valid, distinct data 8'hA0..8'hA3, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; grant_idx 0,1,2,3,0.
- Only requester 2 valid for 5 beats -> 5 consecutive accepts. in_ready=4'b0100 each cycle; grant_idx=2.
- out_ready=0 for 3 cycles while out_valid=1 -> out_data stable, in_ready=0. out_ready=1 -> next winner loaded the same cycle, with no bubble.
- Requesters 1 and 3 valid, ptr=2 after a grant to 1 -> 3 wins, then 1 wins (wrap check).
- With RR_MUX_ARBITER_LOCK_EN: requester 0 sends a 3-beat packet (last on beat 3) while 1 is valid -> beats 0,0,0 then 1. out_last=1 only on the third beat.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter_pkg
// Shared constants, the pick result type and the round-robin search
// function used by the arbiter's combinational picker.
// ----------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

    // Default build configuration
    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;

    // Widest supported requester vector; the search function is written at
    // this width and narrower arbiters zero-extend into it.
    localparam int MAX_REQ = 16;
    localparam int PTR_W   = $clog2(MAX_REQ);

    // Result of one round-robin search
    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Round-robin search: the lowest set bit at or above ptr wins (masked
    // scan); if none exists the lowest set bit overall wins (unmasked scan),
    // which is the wrap from the top index back to 0. Both scans walk from
    // the top down so the last assignment is the lowest qualifying index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [PTR_W-1:0]   ptr);
        pick_t              res;
        logic               masked_hit;
        logic [PTR_W-1:0]   masked_idx;
        logic [PTR_W-1:0]   unmasked_idx;
        masked_hit   = 1'b0;
        masked_idx   = '0;
        unmasked_idx = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                unmasked_idx = PTR_W'(i);
            end
            if (valid[i] && (i >= int'(ptr))) begin
                masked_hit = 1'b1;
                masked_idx = PTR_W'(i);
            end
        end
        res.found = |valid;
        res.idx   = masked_hit ? masked_idx : unmasked_idx;
        return res;
    endfunction

endpackage : rr_mux_arbiter_pkg

// File: rtl/rr_mux_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter_pick
// Purely combinational round-robin priority search. Zero-extends the
// requester vector and pointer to the package search width, runs the
// masked/unmasked double scan and narrows the winner back to IDX_W bits.
// ----------------------------------------------------------------------------
module rr_mux_arbiter_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [PTR_W-1:0]   ptr_ext;
    pick_t              res;
    logic               unused_idx_hi;

    // Widen inputs and run the double scan
    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = valid_i;
        ptr_ext                = '0;
        ptr_ext[IDX_W-1:0]     = ptr_i;
        res                    = rr_pick(valid_ext, ptr_ext);
    end

    // Upper index bits are always zero because valid_ext is zero above N_REQ
    assign found_o       = res.found;
    assign idx_o         = res.idx[IDX_W-1:0];
    assign unused_idx_hi = ^res.idx;

endmodule : rr_mux_arbiter_pick

// File: rtl/rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter for N_REQ valid/ready producers sharing one registered
// output channel. Holds the output register, pointer, load logic and data
// mux; the priority search lives in rr_mux_arbiter_pick.
//
// Optional packet locking is compiled in with RR_MUX_ARBITER_LOCK_EN: adds
// in_last/out_last and keeps the grant on one requester until its last beat.
//
// Handshake: a beat moves from requester i when in_valid[i] && in_ready[i]
// at a rising edge; the output beat moves when out_valid && out_ready.
// in_ready is at most one-hot, only for a valid requester, and only when the
// output register is empty or draining (load = !out_valid || out_ready).
// Producers hold in_valid/in_data until accepted; out_data stays stable while
// out_valid && !out_ready.
// ----------------------------------------------------------------------------
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter  int N_REQ  = N_REQ_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    output logic [N_REQ-1:0]        in_ready,
`ifdef RR_MUX_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]        in_last,
    output logic                    out_last,
`endif
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        grant_idx
);

    // Registered state
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]  ptr_q,       ptr_d;
`ifdef RR_MUX_ARBITER_LOCK_EN
    logic              lock_q,      lock_d;
    logic              out_last_q,  out_last_d;
`endif

    // Arbitration signals
    logic              load;
    logic [N_REQ-1:0]  cand_valid;
    logic              found;
    logic [IDX_W-1:0]  winner;
    logic [DATA_W-1:0] win_data;
    logic [IDX_W-1:0]  winner_inc;

    assign load = !out_valid_q || out_ready;

    // Candidate set: everyone valid, or only the locked owner while a packet is open
`ifdef RR_MUX_ARBITER_LOCK_EN
    always_comb begin
        cand_valid = in_valid;
        if (lock_q) begin
            cand_valid = in_valid & (N_REQ'(1) << grant_idx_q);
        end
    end
`else
    always_comb begin
        cand_valid = in_valid;
    end
`endif

    rr_mux_arbiter_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i (cand_valid),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (winner)
    );

    // Data mux for the current winner
    always_comb begin
        win_data = in_data[int'(winner)*DATA_W +: DATA_W];
    end

    // Pointer moves one past the winner, wrapping at N_REQ-1 (not a power of two in general)
    always_comb begin
        winner_inc = winner + IDX_W'(1);
        if (winner == IDX_W'(N_REQ - 1)) begin
            winner_inc = '0;
        end
    end

    // Ready to the winner only; suppressed during reset so no accept pulse leaks out
    always_comb begin
        in_ready = '0;
        if (rst_n && load && found) begin
            in_ready[winner] = 1'b1;
        end
    end

    // Next-state: load a winner, go empty when nobody is valid, or hold under backpressure
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
`ifdef RR_MUX_ARBITER_LOCK_EN
        lock_d      = lock_q;
        out_last_d  = out_last_q;
`endif
        if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data;
                grant_idx_d = winner;
                ptr_d       = winner_inc;
`ifdef RR_MUX_ARBITER_LOCK_EN
                lock_d      = !in_last[winner];
                out_last_d  = in_last[winner];
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
`ifdef RR_MUX_ARBITER_LOCK_EN
            lock_q      <= 1'b0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
`ifdef RR_MUX_ARBITER_LOCK_EN
            lock_q      <= lock_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant_idx = grant_idx_q;
`ifdef RR_MUX_ARBITER_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Directed bench for rr_mux_arbiter (N_REQ=4, DATA_W=8). Stimulus pushes
// hand-computed {last, grant_idx, data} beats into exp_q; a negedge monitor
// pops one entry per output handshake. Also covers RR_MUX_ARBITER_LOCK_EN
// when that macro is defined for both files.
// ----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int EW = 1 + IW + W;
`ifdef RR_MUX_ARBITER_LOCK_EN
  localparam logic DFLT_LAST = 1'b1;
`else
  localparam logic DFLT_LAST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [IW-1:0]  grant_idx;
  logic           out_last_w;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
  assign out_last_w = out_last;
`else
  assign out_last_w = 1'b0;
`endif

  rr_mux_arbiter #(
    .N_REQ  (N),
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef RR_MUX_ARBITER_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_l(input logic last, input logic [IW-1:0] idx, input logic [W-1:0] d);
    exp_q.push_back({last, idx, d});
  endtask

  task automatic push(input logic [IW-1:0] idx, input logic [W-1:0] d);
    push_l(DFLT_LAST, idx, d);
  endtask

  // Monitor: one expected entry per accepted output beat
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", {out_last_w, grant_idx, out_data});
      end else begin
        check("out_beat", 32'({out_last_w, grant_idx, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_data(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  // One cycle: check in_ready at negedge, then advance to just after the edge
  task automatic step_ready(input logic [N-1:0] exp_rdy, input string name);
    @(negedge clk);
    check(name, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef RR_MUX_ARBITER_LOCK_EN
    in_last   = 4'hF;
`endif
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));

    // Reset state, with requesters valid: no ready pulse during reset
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // Idle for 10 cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_grant_idx", 32'(grant_idx), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end

    // All four valid: 0,1,2,3,0
    out_ready = 1'b1;
    in_valid  = 4'hF;
    push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3); push(0, 8'hA0);
    for (int k = 0; k < 5; k++) step_ready(4'(1 << (k % 4)), "rr_all_ready");
    in_valid = '0;
    step_ready(4'b0000, "rr_all_drain");
    step_ready(4'b0000, "rr_all_idle");

    // Lone requester 2 for five beats (ptr is 1)
    in_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      set_data(2, 8'h20 + 8'(k));
      push(2, 8'h20 + 8'(k));
      step_ready(4'b0100, "lone2_ready");
    end
    in_valid = '0;
    step_ready(4'b0000, "lone2_drain");
    step_ready(4'b0000, "lone2_idle");

    // Backpressure: ptr=3, 0 and 1 valid -> 0 wins, then stall 3 cycles
    in_valid = 4'b0011;
    set_data(0, 8'hB0);
    set_data(1, 8'hB1);
    push(0, 8'hB0);
    push(1, 8'hB1);
    step_ready(4'b0001, "bp_first_ready");
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'hB0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    step_ready(4'b0010, "bp_release_ready");
    in_valid = '0;
    step_ready(4'b0000, "bp_drain");
    step_ready(4'b0000, "bp_idle");

    // Wrap: ptr=2 after grant to 1; 1 and 3 valid -> 3 then 1
    in_valid = 4'b1010;
    set_data(1, 8'hC1);
    set_data(3, 8'hC3);
    push(3, 8'hC3);
    push(1, 8'hC1);
    step_ready(4'b1000, "wrap_first_ready");
    in_valid = 4'b0010;
    step_ready(4'b0010, "wrap_second_ready");
    in_valid = '0;
    step_ready(4'b0000, "wrap_drain");
    step_ready(4'b0000, "wrap_idle");

    // Lone requester 0 with ptr=2
    in_valid = 4'b0001;
    set_data(0, 8'h5A);
    push(0, 8'h5A);
    step_ready(4'b0001, "lone0_ready");
    in_valid = '0;
    step_ready(4'b0000, "lone0_drain");

    // Mid-stream reset: load a beat (ptr=1 -> requester 1), stall, then reset
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));
    step_ready(4'b0010, "mid_load_ready");
    @(negedge clk);
    check("mid_stall_ready", 32'(in_ready), 32'd0);
    check("mid_held_data", 32'(out_data), 32'hA1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_grant_idx", 32'(grant_idx), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = '0;
    rst_n    = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;

`ifdef RR_MUX_ARBITER_LOCK_EN
    // Packet lock: 0 sends D0,D1,D2(last) while 1 is valid, then 1 gets E1
    in_valid = 4'b0011;
    set_data(1, 8'hE1);
    in_last  = 4'b1110;
    set_data(0, 8'hD0);
    push_l(1'b0, 0, 8'hD0);
    step_ready(4'b0001, "lock_beat1_ready");
    set_data(0, 8'hD1);
    push_l(1'b0, 0, 8'hD1);
    step_ready(4'b0001, "lock_beat2_ready");
    set_data(0, 8'hD2);
    in_last = 4'b1111;
    push_l(1'b1, 0, 8'hD2);
    step_ready(4'b0001, "lock_beat3_ready");
    in_valid = 4'b0010;
    push_l(1'b1, 1, 8'hE1);
    step_ready(4'b0010, "lock_after_ready");
    in_valid = '0;
    step_ready(4'b0000, "lock_drain");
`else
    // Pointer cleared by reset: all valid -> requester 0 wins first
    in_valid = 4'hF;
    push(0, 8'hA0);
    step_ready(4'b0001, "post_rst_ready");
    in_valid = '0;
    step_ready(4'b0000, "post_rst_drain");
`endif
    step_ready(4'b0000, "final_idle");

    // Every expected beat must have been observed
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
